// File: rtl/echo_linebuf.sv
// echo_linebuf: receive-side byte FIFO feeding a transmitter handshake.
// Bytes from the receiver are queued in a circular buffer and replayed
// to the transmitter in order, with optional CR -> CR,LF expansion.
// A line break flushes the queue and drops any byte in flight.
module echo_linebuf #(
    parameter int   LGFLEN   = 4,
    parameter logic OPT_CRLF = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_rx_stb,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_break,
    output logic              o_tx_stb,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    input  logic              i_clr_ovfl,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_overflow
);

    localparam int               DEPTH   = 1 << LGFLEN;
    localparam logic [LGFLEN:0]  PTR_ONE = {{LGFLEN{1'b0}}, 1'b1};
    localparam logic [LGFLEN:0]  PTR_MSB = {1'b1, {LGFLEN{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2,
        LF   = 2'd3
    } state_t;

    logic [1:0]       rst_sync_q;
    logic [1:0]       rst_sync_d;
    logic             rst_n_int;

    logic [7:0]       fifo_mem [DEPTH];
    logic [LGFLEN:0]  wr_ptr_q, wr_ptr_d;
    logic [LGFLEN:0]  rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    state_t           state_q, state_d;
    logic             tx_stb_q, tx_stb_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             lf_pend_q, lf_pend_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             ovfl_set;
    logic [7:0]       head;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    // Reset assertion is immediate; release is delayed two edges so every
    // state flop leaves reset together and the release edge accepts nothing.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);
    assign head  = fifo_mem[rd_ptr_q[LGFLEN-1:0]];

    // Output sequencer: pop a byte, offer it until taken, pause one cycle so
    // the transmitter can raise busy, and splice in an LF after a CR.
    // From IDLE a byte is only offered once the transmitter reports free.
    always_comb begin
        state_d   = state_q;
        tx_stb_d  = tx_stb_q;
        tx_data_d = tx_data_q;
        lf_pend_d = lf_pend_q;
        pop       = 1'b0;
        if (i_rx_break) begin
            state_d   = IDLE;
            tx_stb_d  = 1'b0;
            lf_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty && !i_tx_busy) begin
                        pop       = 1'b1;
                        tx_data_d = head;
                        tx_stb_d  = 1'b1;
                        state_d   = SEND;
                    end
                end
                SEND: begin
                    if (!i_tx_busy) begin
                        tx_stb_d  = 1'b0;
                        state_d   = HOLD;
                        lf_pend_d = OPT_CRLF && (tx_data_q == 8'h0D);
                    end
                end
                LF: begin
                    if (!i_tx_busy) begin
                        tx_stb_d  = 1'b0;
                        state_d   = HOLD;
                        lf_pend_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (lf_pend_q) begin
                        tx_data_d = 8'h0A;
                        tx_stb_d  = 1'b1;
                        lf_pend_d = 1'b0;
                        state_d   = LF;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        tx_data_d = head;
                        tx_stb_d  = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    tx_stb_d = 1'b0;
                end
            endcase
        end
    end

    // Queue bookkeeping: a push into a full queue is still taken when the
    // sequencer pops in the same cycle, otherwise the byte is dropped and
    // the sticky overflow flag wins over a coincident clear.
    always_comb begin
        push       = i_rx_stb && !i_rx_break && (!full || pop);
        ovfl_set   = i_rx_stb && !i_rx_break && full && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (i_rx_break) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
        if (ovfl_set) begin
            overflow_d = 1'b1;
        end else if (i_clr_ovfl) begin
            overflow_d = 1'b0;
        end
    end

    // Byte storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[LGFLEN-1:0]] <= i_rx_data;
        end
    end

    // All control state, cleared together by the synchronised reset.
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            tx_stb_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            lf_pend_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            tx_stb_q   <= tx_stb_d;
            tx_data_q  <= tx_data_d;
            lf_pend_q  <= lf_pend_d;
        end
    end

    assign o_tx_stb   = tx_stb_q;
    assign o_tx_data  = tx_data_q;
    assign o_fill     = wr_ptr_q - rd_ptr_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_echo_linebuf.sv
// Directed testbench for echo_linebuf: ordering, CR/LF expansion,
// overflow handling, break flush and asynchronous reset.
module tb_echo_linebuf;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_rx_stb;
    logic [7:0]  i_rx_data;
    logic        i_rx_break;
    logic        o_tx_stb;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;
    logic        i_clr_ovfl;
    logic [4:0]  o_fill;
    logic        o_overflow;

    logic        rx2_stb;
    logic [7:0]  rx2_data;
    logic        tx2_stb;
    logic [7:0]  tx2_data;
    logic [4:0]  fill2;
    logic        ovfl2;

    int          num_checks;
    int          num_fails;

    echo_linebuf #(.LGFLEN(4), .OPT_CRLF(1'b1)) u_dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_rx_stb   (i_rx_stb),
        .i_rx_data  (i_rx_data),
        .i_rx_break (i_rx_break),
        .o_tx_stb   (o_tx_stb),
        .o_tx_data  (o_tx_data),
        .i_tx_busy  (i_tx_busy),
        .i_clr_ovfl (i_clr_ovfl),
        .o_fill     (o_fill),
        .o_overflow (o_overflow)
    );

    echo_linebuf #(.LGFLEN(4), .OPT_CRLF(1'b0)) u_dut_nocrlf (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_rx_stb   (rx2_stb),
        .i_rx_data  (rx2_data),
        .i_rx_break (1'b0),
        .o_tx_stb   (tx2_stb),
        .o_tx_data  (tx2_data),
        .i_tx_busy  (1'b0),
        .i_clr_ovfl (1'b0),
        .o_fill     (fill2),
        .o_overflow (ovfl2)
    );

    // Free-running 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Single comparison point: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one received byte for one cycle; called on a falling edge.
    task automatic applyStimulus(input logic [7:0] data);
        i_rx_stb  = 1'b1;
        i_rx_data = data;
        @(negedge i_clk);
        i_rx_stb  = 1'b0;
    endtask

    // Wait a bounded number of cycles for the next offered byte and check it.
    task automatic expectTx(input string tag, input logic [7:0] expected);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            if (o_tx_stb) seen = 1'b1;
        end
        checkOutput({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) checkOutput(tag, {24'd0, o_tx_data}, {24'd0, expected});
    endtask

    // Count cycles with a byte offered over a fixed window.
    task automatic countTx(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_clk);
            if (o_tx_stb) cnt++;
        end
    endtask

    initial begin
        logic [7:0] push_tbl [3];
        logic       exp_stb  [9];
        logic [7:0] exp_data [9];
        int         cnt;
        logic [7:0] cap;

        num_checks = 0;
        num_fails  = 0;
        i_reset_n  = 1'b0;
        i_rx_stb   = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_break = 1'b0;
        i_tx_busy  = 1'b0;
        i_clr_ovfl = 1'b0;
        rx2_stb    = 1'b0;
        rx2_data   = 8'h00;

        repeat (3) @(negedge i_clk);
        checkOutput("rst_fill", {27'd0, o_fill}, 32'd0);
        checkOutput("rst_ovfl", {31'd0, o_overflow}, 32'd0);
        checkOutput("rst_stb", {31'd0, o_tx_stb}, 32'd0);
        checkOutput("rst_data", {24'd0, o_tx_data}, 32'h00);
        i_reset_n = 1'b1;
        repeat (4) @(negedge i_clk);

        // Three bytes back to back with a free transmitter.
        push_tbl = '{8'h41, 8'h42, 8'h43};
        exp_stb  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_data = '{8'h00, 8'h00, 8'h41, 8'h00, 8'h42, 8'h00, 8'h43, 8'h00, 8'h00};
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge i_clk);
            if (k > 0) begin
                checkOutput($sformatf("abc_stb%0d", k), {31'd0, o_tx_stb}, {31'd0, exp_stb[k]});
                if (exp_stb[k]) checkOutput($sformatf("abc_data%0d", k), {24'd0, o_tx_data}, {24'd0, exp_data[k]});
            end
            i_rx_stb  = (k < 3);
            i_rx_data = (k < 3) ? push_tbl[k] : 8'h00;
        end
        checkOutput("abc_fill", {27'd0, o_fill}, 32'd0);

        // CR expands to CR,LF.
        applyStimulus(8'h0D);
        checkOutput("cr_fill1", {27'd0, o_fill}, 32'd1);
        checkOutput("cr_stb1", {31'd0, o_tx_stb}, 32'd0);
        @(negedge i_clk);
        checkOutput("cr_stb2", {31'd0, o_tx_stb}, 32'd1);
        checkOutput("cr_data2", {24'd0, o_tx_data}, 32'h0D);
        @(negedge i_clk);
        checkOutput("cr_stb3", {31'd0, o_tx_stb}, 32'd0);
        checkOutput("cr_fill3", {27'd0, o_fill}, 32'd0);
        @(negedge i_clk);
        checkOutput("lf_stb4", {31'd0, o_tx_stb}, 32'd1);
        checkOutput("lf_data4", {24'd0, o_tx_data}, 32'h0A);
        countTx(4, cnt);
        checkOutput("lf_after", cnt, 32'd0);

        // Without expansion a CR is a single byte.
        rx2_stb  = 1'b1;
        rx2_data = 8'h0D;
        @(negedge i_clk);
        rx2_stb  = 1'b0;
        cnt = 0;
        cap = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (tx2_stb) begin
                cnt++;
                cap = tx2_data;
            end
        end
        checkOutput("nocrlf_cnt", cnt, 32'd1);
        checkOutput("nocrlf_data", {24'd0, cap}, 32'h0D);

        // Fill with the transmitter busy: 16 held, 17th dropped.
        i_tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) applyStimulus(8'h10 + 8'(i));
        checkOutput("full_fill", {27'd0, o_fill}, 32'd16);
        checkOutput("full_ovfl", {31'd0, o_overflow}, 32'd1);
        checkOutput("full_stb", {31'd0, o_tx_stb}, 32'd0);
        i_clr_ovfl = 1'b1;
        applyStimulus(8'hEF);
        i_clr_ovfl = 1'b0;
        checkOutput("ovfl_clr_coinc", {31'd0, o_overflow}, 32'd1);
        checkOutput("ovfl_coinc_fill", {27'd0, o_fill}, 32'd16);
        i_clr_ovfl = 1'b1;
        @(negedge i_clk);
        i_clr_ovfl = 1'b0;
        checkOutput("ovfl_cleared", {31'd0, o_overflow}, 32'd0);

        // Release busy while pushing into the full queue.
        i_tx_busy = 1'b0;
        applyStimulus(8'hA5);
        checkOutput("pp_fill", {27'd0, o_fill}, 32'd16);
        checkOutput("pp_ovfl", {31'd0, o_overflow}, 32'd0);
        checkOutput("pp_stb", {31'd0, o_tx_stb}, 32'd1);
        checkOutput("pp_data", {24'd0, o_tx_data}, 32'h10);
        for (int i = 1; i < 16; i++) expectTx($sformatf("drain%0d", i), 8'h10 + 8'(i));
        expectTx("drain_last", 8'hA5);
        countTx(8, cnt);
        checkOutput("drain_extra", cnt, 32'd0);
        checkOutput("drain_fill", {27'd0, o_fill}, 32'd0);

        // Break flushes the queue and swallows the coincident byte.
        i_tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(8'h31 + 8'(i));
        checkOutput("brk_pre_fill", {27'd0, o_fill}, 32'd5);
        i_rx_break = 1'b1;
        applyStimulus(8'h99);
        i_rx_break = 1'b0;
        checkOutput("brk_fill", {27'd0, o_fill}, 32'd0);
        checkOutput("brk_stb", {31'd0, o_tx_stb}, 32'd0);
        i_tx_busy = 1'b0;
        countTx(8, cnt);
        checkOutput("brk_nothing", cnt, 32'd0);
        applyStimulus(8'h55);
        expectTx("brk_next", 8'h55);
        countTx(6, cnt);

        // Asynchronous reset while offering a byte with overflow set.
        i_tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) applyStimulus(8'h60 + 8'(i));
        checkOutput("ar_pre_ovfl", {31'd0, o_overflow}, 32'd1);
        i_tx_busy = 1'b0;
        @(negedge i_clk);
        i_tx_busy = 1'b1;
        checkOutput("ar_pre_stb", {31'd0, o_tx_stb}, 32'd1);
        checkOutput("ar_pre_data", {24'd0, o_tx_data}, 32'h60);
        repeat (3) @(negedge i_clk);
        checkOutput("hold_stb", {31'd0, o_tx_stb}, 32'd1);
        checkOutput("hold_data", {24'd0, o_tx_data}, 32'h60);
        #2 i_reset_n = 1'b0;
        #1;
        checkOutput("ar_stb", {31'd0, o_tx_stb}, 32'd0);
        checkOutput("ar_data", {24'd0, o_tx_data}, 32'h00);
        checkOutput("ar_fill", {27'd0, o_fill}, 32'd0);
        checkOutput("ar_ovfl", {31'd0, o_overflow}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        applyStimulus(8'hEE);
        repeat (3) @(negedge i_clk);
        checkOutput("release_nopush", {27'd0, o_fill}, 32'd0);
        i_tx_busy = 1'b0;
        applyStimulus(8'h77);
        expectTx("post_reset_first", 8'h77);
        countTx(6, cnt);
        checkOutput("post_reset_extra", cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
